// File: rtl/ysyx_20020207_lsu_if.sv
// ysyx_20020207_lsu bus interface
// AXI4-Lite style master port of the load/store unit
interface ysyx_20020207_lsu_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready,
    output awaddr, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  araddr, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready,
    input  awaddr, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/ysyx_20020207_lsu.sv
// ysyx_20020207_lsu: RV32I load/store unit, one bus access per request.
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN.
module ysyx_20020207_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      addr_valid,
  input  logic [31:0]               lsu_addr,
  input  logic [31:0]               lsu_wdata,
  input  logic                      lsu_ren,
  input  logic                      lsu_wen,
  input  logic [2:0]                lsu_funct3,
  output logic                      lsu_valid,
  output logic [31:0]               lsu_rdata,
  output logic                      lsu_err,
  output logic                      lsu_busy,
  ysyx_20020207_lsu_if.master       bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WRITE,
    S_WRESP,
    S_DONE
  } state_e;

  state_e      state_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        lsu_valid_q;
  logic [31:0] lsu_rdata_q;
  logic        lsu_err_q;
  logic        busy_q;
  logic [31:0] araddr_q;
  logic        arvalid_q;
  logic        rready_q;
  logic [31:0] awaddr_q;
  logic        awvalid_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        wvalid_q;
  logic        bready_q;

  logic        legal_d;
  logic [3:0]  strb_d;
  logic [31:0] wsh_d;
  logic [31:0] ext_d;
  logic [31:0] lsh;
  logic [3:0]  sbase;
  logic        f3_ok;
  logic        al_ok;
  logic        tmo_hit;

  // Request legality: one op, known funct3, natural alignment
  always_comb begin
    f3_ok = 1'b0;
    al_ok = 1'b1;
    unique case (lsu_funct3)
      3'b000, 3'b100: f3_ok = 1'b1;
      3'b001, 3'b101: begin
        f3_ok = 1'b1;
        al_ok = ~lsu_addr[0];
      end
      3'b010: begin
        f3_ok = 1'b1;
        al_ok = (lsu_addr[1:0] == 2'b00);
      end
      default: f3_ok = 1'b0;
    endcase
    legal_d = (lsu_ren ^ lsu_wen) & f3_ok & al_ok;
  end

  // Store lane placement and byte strobes
  always_comb begin
    unique case (lsu_funct3[1:0])
      2'b00:   sbase = 4'b0001;
      2'b01:   sbase = 4'b0011;
      default: sbase = 4'b1111;
    endcase
    strb_d = sbase << lsu_addr[1:0];
    wsh_d  = lsu_wdata << {lsu_addr[1:0], 3'b000};
  end

  // Load lane extraction with sign/zero extension
  always_comb begin
    lsh = bus.rdata >> {off_q, 3'b000};
    unique case (f3_q)
      3'b000:  ext_d = {{24{lsh[7]}}, lsh[7:0]};
      3'b100:  ext_d = {24'b0, lsh[7:0]};
      3'b001:  ext_d = {{16{lsh[15]}}, lsh[15:0]};
      3'b101:  ext_d = {16'b0, lsh[15:0]};
      default: ext_d = lsh;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [31:0] tmo_q;
  logic        in_bus;

  assign in_bus = (state_q == S_RADDR) || (state_q == S_RDATA) ||
                  (state_q == S_WRITE) || (state_q == S_WRESP);
  assign tmo_hit = in_bus && (tmo_q == 32'(TIMEOUT_CYCLES - 1));

  // Watchdog: cleared while idle, counts every cycle spent on the bus
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= 32'd0;
    end else if (state_q == S_IDLE) begin
      tmo_q <= 32'd0;
    end else if (in_bus) begin
      tmo_q <= tmo_q + 32'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Main FSM with registered bus and completion outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      off_q       <= 2'b00;
      f3_q        <= 3'b000;
      lsu_valid_q <= 1'b0;
      lsu_rdata_q <= 32'd0;
      lsu_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      araddr_q    <= 32'd0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= 32'd0;
      awvalid_q   <= 1'b0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'b0000;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
    end else begin
      lsu_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (addr_valid && (lsu_ren || lsu_wen)) begin
            off_q  <= lsu_addr[1:0];
            f3_q   <= lsu_funct3;
            busy_q <= 1'b1;
            if (!legal_d) begin
              state_q     <= S_DONE;
              lsu_valid_q <= 1'b1;
              lsu_err_q   <= 1'b1;
              lsu_rdata_q <= 32'd0;
            end else if (lsu_ren) begin
              state_q   <= S_RADDR;
              arvalid_q <= 1'b1;
              araddr_q  <= {lsu_addr[31:2], 2'b00};
            end else begin
              state_q   <= S_WRITE;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              awaddr_q  <= {lsu_addr[31:2], 2'b00};
              wdata_q   <= wsh_d;
              wstrb_q   <= strb_d;
            end
          end
        end
        S_RADDR: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (bus.rvalid) begin
            rready_q    <= 1'b0;
            state_q     <= S_DONE;
            lsu_valid_q <= 1'b1;
            lsu_err_q   <= (bus.rresp != 2'b00);
            lsu_rdata_q <= (bus.rresp != 2'b00) ? 32'd0 : ext_d;
          end
        end
        S_WRITE: begin
          if (bus.awready) awvalid_q <= 1'b0;
          if (bus.wready) wvalid_q <= 1'b0;
          if ((!awvalid_q || bus.awready) &&
              (!wvalid_q || bus.wready)) begin
            bready_q <= 1'b1;
            state_q  <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (bus.bvalid) begin
            bready_q    <= 1'b0;
            state_q     <= S_DONE;
            lsu_valid_q <= 1'b1;
            lsu_err_q   <= (bus.bresp != 2'b00);
            lsu_rdata_q <= 32'd0;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (tmo_hit) begin
        arvalid_q   <= 1'b0;
        rready_q    <= 1'b0;
        awvalid_q   <= 1'b0;
        wvalid_q    <= 1'b0;
        bready_q    <= 1'b0;
        state_q     <= S_DONE;
        lsu_valid_q <= 1'b1;
        lsu_err_q   <= 1'b1;
        lsu_rdata_q <= 32'd0;
      end
    end
  end

  assign lsu_valid   = lsu_valid_q;
  assign lsu_rdata   = lsu_rdata_q;
  assign lsu_err     = lsu_err_q;
  assign lsu_busy    = busy_q;
  assign bus.araddr  = araddr_q;
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = rready_q;
  assign bus.awaddr  = awaddr_q;
  assign bus.awvalid = awvalid_q;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = wstrb_q;
  assign bus.wvalid  = wvalid_q;
  assign bus.bready  = bready_q;

endmodule

// File: doc/ysyx_20020207_lsu.md
Name: ysyx_20020207_lsu

Overview:
Load/store unit that consumes the ALU's effective-address output (lsu_addr qualified by the addr_valid pulse) and performs one memory access per request on an AXI4-Lite-style master port. It handles RV32I byte/half/word loads and stores: store data lane shifting, byte strobes, and load extraction with sign/zero extension. It returns the load data to writeback with a one-cycle lsu_valid pulse.

Parameters:
TIMEOUT_CYCLES, 255, bus-response watchdog limit in cycles (used only with LSU_TIMEOUT_EN)

Ports:
clock  in  1  system clock; all state on posedge
reset_n  in  1  asynchronous, active-low reset
addr_valid  in  1  one-cycle pulse from ALU; lsu_addr valid this cycle
lsu_addr  in  32  effective byte address
lsu_wdata  in  32  store data (rs2), right-aligned
lsu_ren  in  1  request is a load
lsu_wen  in  1  request is a store
lsu_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
lsu_valid  out  1  one-cycle completion pulse
lsu_rdata  out  32  extended load data (0 for stores/errors), held until next completion
lsu_err  out  1  completion was an error; valid with lsu_valid
lsu_busy  out  1  request in flight (state != IDLE)
araddr, arvalid, arready  out/out/in  32/1/1  read address channel
rdata, rresp, rvalid, rready  in/in/in/out  32/2/1/1  read data channel
awaddr, awvalid, awready  out/out/in  32/1/1  write address channel
wdata, wstrb, wvalid, wready  out/out/out/in  32/4/1/1  write data channel
bresp, bvalid, bready  in/in/out  2/1/1  write response channel

Behaviour:
- Reset (async assert, sync release): state IDLE; all valid/ready outputs, lsu_valid, lsu_err and lsu_busy are 0; lsu_rdata, addresses, wdata and wstrb are 0.
- Accept: in IDLE with addr_valid=1 and exactly one of ren/wen set, latch addr, wdata, funct3 and op. addr_valid with neither set is ignored. addr_valid while busy is ignored (not queued).
- Illegal requests: ren&wen both set, misaligned H/HU (addr[0]=1), misaligned W (addr[1:0]!=0), or a reserved funct3 go to DONE. No bus traffic; lsu_err=1, lsu_rdata=0.
- States: IDLE -> RADDR -> RDATA -> DONE for loads; IDLE -> WRITE -> WRESP -> DONE for stores; DONE -> IDLE unconditionally.
- RADDR: arvalid=1, araddr={addr[31:2],2'b00}; move on the ar handshake. RDATA: rready=1; on the r handshake, capture the extracted data and set err=(rresp!=0).
- WRITE: assert awvalid and wvalid together. Each drops independently at its own handshake; leave the state when both are done, in either order or in the same cycle.
- Store lane placement: wdata = lsu_wdata << (8*addr[1:0]). wstrb = 0001 (B), 0011 (H) or 1111 (W), shifted left by addr[1:0].
- WRESP: bready=1; on the b handshake set err=(bresp!=0).
- Load extraction: s = rdata >> (8*addr[1:0]). B gives sext(s[7:0]); BU gives zext(s[7:0]); H gives sext(s[15:0]); HU gives zext(s[15:0]); W gives s. On error, lsu_rdata=0.
- DONE: lsu_valid=1 for exactly one cycle; lsu_rdata and lsu_err update in the same cycle.
- Valid outputs stay stable until their handshake (AXI rule); addresses and data do not change while valid is high.
- Latency with a zero-wait slave (ready always 1, response the cycle after handshake): lsu_valid is high in the 3rd cycle after the acceptance cycle, for both loads and stores.
- An addr_valid in the same cycle as lsu_valid is ignored (state is DONE); the next request is accepted from IDLE.
- reset_n asserted mid-transaction abandons the transaction immediately. No bus state is preserved.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: an 8..32-bit counter clears on entering RADDR/WRITE and counts while in RADDR, RDATA, WRITE or WRESP. When it reaches TIMEOUT_CYCLES, all bus valid/ready outputs drop and the block goes to DONE with lsu_err=1 and lsu_rdata=0.
- Undefined: no counter; the block waits indefinitely for the slave.

Test Plan:
- Load: LW addr 0x80000004, zero-wait slave rdata=0xDEADBEEF -> araddr 0x80000004; lsu_valid in 3rd cycle after accept; lsu_rdata=0xDEADBEEF, err=0.
- Sign/zero extension: rdata=0x80FF7F01. LB@+1 -> 0x0000007F; LB@+2 -> 0xFFFFFFFF; LBU@+3 -> 0x00000080; LH@+2 -> 0xFFFF80FF; LHU@+0 -> 0x00007F01.
- Store placement: SB addr 0x...3, rs2=0x12345678 -> wdata 0x78000000, wstrb 1000. SH addr 0x...2 -> wdata 0x56780000, wstrb 1100. Slave raises awready 3 cycles before wready -> single completion.
- Misalign/illegal: LW addr 0x...2 -> no arvalid, lsu_valid one cycle later path with err=1, rdata=0. ren=wen=1 -> same.
- Error/backpressure: arready held low 5 cycles -> arvalid and araddr stable; rresp=2'b10 -> err=1, rdata=0. addr_valid pulse while busy -> ignored, exactly one lsu_valid.
- Reset mid-RDATA: reset_n low -> all valids 0 asynchronously; after release, LW completes normally. With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=16, a slave that never returns rvalid -> err pulse after 16 cycles.
